// File: rtl/cdb_pkg.sv
// Shared CDB definitions: default widths, broadcast message type and round-robin pointer helper.
package cdb_pkg;

  localparam int unsigned CDB_TAG_W  = 6;
  localparam int unsigned CDB_DATA_W = 32;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_msg_t;

  // Successor of a granted index, wrapping for non-power-of-two requester counts.
  function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
    return (g == n - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational picker: first set request at or above ptr (with wrap) wins; ptr=0 gives fixed priority.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int unsigned      sum;
  logic [IDX_W-1:0] k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    sum = 0;
    k   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = 32'(ptr) + i;
      if (sum >= N) sum = sum - N;
      k = IDX_W'(sum);
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one grant per cycle, registered broadcast one cycle later.
// Define CDB_RR_EN for round-robin arbitration; otherwise fixed priority (index 0 highest).
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = CDB_TAG_W,
  parameter int unsigned DATA_W  = CDB_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [TAG_W-1:0]   tag_arr  [NUM_REQ];
  logic [DATA_W-1:0]  data_arr [NUM_REQ];
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gidx;
  logic [IDX_W-1:0]   pick_ptr;
  logic               any_req;
  logic               fire;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign tag_arr[i]  = req_tag[i*TAG_W +: TAG_W];
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (req_valid),
    .ptr (pick_ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (any_req)
  );

  // Grant is masked while reset is asserted so no unit sees a phantom handshake.
  assign fire      = rst && !flush && any_req;
  assign req_ready = fire ? gnt : '0;

`ifdef CDB_RR_EN
  logic [IDX_W-1:0] rr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (fire) begin
      rr_ptr <= IDX_W'(rr_next(32'(gidx), NUM_REQ));
    end
  end

  assign pick_ptr = rr_ptr;
`else
  assign pick_ptr = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
    end else begin
      cdb_valid <= fire;
      if (fire) begin
        cdb_tag  <= tag_arr[gidx];
        cdb_data <= data_arr[gidx];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter (NUM_REQ=4 main instance, NUM_REQ=3 wrap instance).
module tb_cdb_arbiter;

`ifdef CDB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [3:0]  rv;
  logic [5:0]  tags  [4];
  logic [31:0] datas [4];
  logic [23:0] rt;
  logic [127:0] rd;
  logic [3:0]  req_ready;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;

  logic [2:0]  rv3;
  logic [17:0] rt3 = {6'h11, 6'h22, 6'h2A};
  logic [95:0] rd3 = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
  logic [2:0]  rdy3;
  logic        cdb_valid3;
  logic [5:0]  cdb_tag3;
  logic [31:0] cdb_data3;

  assign rt = {tags[3], tags[2], tags[1], tags[0]};
  assign rd = {datas[3], datas[2], datas[1], datas[0]};

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(4), .TAG_W(6), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (rv),
    .req_tag   (rt),
    .req_data  (rd),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data)
  );

  cdb_arbiter #(.NUM_REQ(3), .TAG_W(6), .DATA_W(32)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .req_valid (rv3),
    .req_tag   (rt3),
    .req_data  (rd3),
    .req_ready (rdy3),
    .cdb_valid (cdb_valid3),
    .cdb_tag   (cdb_tag3),
    .cdb_data  (cdb_data3)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int          mptr;
  logic        exp_v;
  logic [5:0]  exp_t;
  logic [31:0] exp_d;
  int          last_g;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] v, input int ptr, input int n, input bit rr);
    for (int k = 0; k < n; k++) begin
      int cand;
      cand = rr ? (ptr + k) % n : k;
      if (v[cand]) return cand;
    end
    return -1;
  endfunction

  // One cycle on the main DUT: drive, check grant, clock, check broadcast.
  task automatic step(input logic [3:0] v, input logic fl, input string tag);
    int g;
    logic [3:0] exp_rdy;
    rv = v;
    flush = fl;
    #1;
    g = fl ? -1 : pick({4'b0, v}, mptr, 4, RR);
    exp_rdy = (g < 0) ? 4'b0 : 4'(1 << g);
    check({tag, "_ready"}, 64'(req_ready), 64'(exp_rdy));
    if (g >= 0) begin
      exp_v = 1'b1;
      exp_t = tags[g];
      exp_d = datas[g];
      if (RR) mptr = (g + 1) % 4;
    end else begin
      exp_v = 1'b0;
    end
    @(posedge clk);
    #1;
    check({tag, "_cdb_valid"}, 64'(cdb_valid), 64'(exp_v));
    if (exp_v) begin
      check({tag, "_cdb_tag"}, 64'(cdb_tag), 64'(exp_t));
      check({tag, "_cdb_data"}, 64'(cdb_data), 64'(exp_d));
    end
    last_g = g;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_cdb_valid", 64'(cdb_valid), 64'(0));
    mptr = 0;
    exp_v = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [3:0] pend;
    int gseq [5];

    for (int i = 0; i < 4; i++) begin
      tags[i]  = 6'(i + 1);
      datas[i] = 32'h1000_0000 + 32'(i);
    end
    flush = 1'b0;
    rv    = 4'hF;
    rv3   = 3'b000;
    mptr  = 0;
    exp_v = 1'b0;

    // 1: reset with all requests pending
    rst = 1'b0;
    #1;
    check("t1_ready_in_reset", 64'(req_ready), 64'(0));
    check("t1_cdb_valid", 64'(cdb_valid), 64'(0));
    check("t1_cdb_tag", 64'(cdb_tag), 64'(0));
    check("t1_cdb_data", 64'(cdb_data), 64'(0));
    @(posedge clk);
    #1;
    check("t1_ready_held", 64'(req_ready), 64'(0));
    rst = 1'b1;
    #1;
    check("t1_ready_release", 64'(req_ready), 64'(4'b0001));
    step(4'hF, 1'b0, "t1_first");

    // 2: single unit
    tags[2]  = 6'h15;
    datas[2] = 32'hDEADBEEF;
    step(4'b0100, 1'b0, "t2_single");
    check("t2_tag_const", 64'(cdb_tag), 64'(6'h15));
    check("t2_data_const", 64'(cdb_data), 64'(32'hDEADBEEF));
    step(4'b0000, 1'b0, "t2_idle");

    // 3: contention from pointer 0
    do_reset();
    for (int i = 0; i < 5; i++) gseq[i] = RR ? (i % 4) : 0;
    for (int i = 0; i < 5; i++) begin
      step(4'hF, 1'b0, "t3_contend");
      check("t3_grant_index", 64'(last_g), 64'(gseq[i]));
    end

    // 5: flush holds off a pending request and leaves the pointer alone
    step(4'b0010, 1'b1, "t5_flush");
    step(4'b0010, 1'b0, "t5_after");
    check("t5_grant_index", 64'(last_g), 64'(1));
    step(4'b0000, 1'b0, "t5_idle");

    // 4: wrap on the 3-requester instance
    do_reset();
    rv3 = 3'b010;
    #1;
    check("t4_ready_a", 64'(rdy3), 64'(3'b010));
    step(4'b0000, 1'b0, "t4_idle_a");
    rv3 = 3'b011;
    #1;
    check("t4_wrap_grant", 64'(rdy3), 64'(3'b001));
    step(4'b0000, 1'b0, "t4_idle_b");
    #1;
    check("t4_wrap_cdb_tag", 64'(cdb_tag3), 64'(6'h2A));
    check("t4_ptr_after_wrap", 64'(rdy3), RR ? 64'(3'b010) : 64'(3'b001));
    rv3 = 3'b000;

    // 6: async reset with a broadcast in flight
    step(4'hF, 1'b0, "t6_pre");
    check("t6_in_flight", 64'(cdb_valid), 64'(1));
    rst = 1'b0;
    #1;
    check("t6_async_valid", 64'(cdb_valid), 64'(0));
    check("t6_async_ready", 64'(req_ready), 64'(0));
    mptr = 0;
    exp_v = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(4'b1110, 1'b0, "t6_ptr_zero");
    check("t6_grant_index", 64'(last_g), 64'(1));

    // Randomized traffic: units hold requests until granted
    pend = 4'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i]  = 1'b1;
          tags[i]  = 6'($urandom);
          datas[i] = $urandom;
        end
      end
      step(pend, 1'($urandom_range(0, 7) == 0), "rand");
      if (last_g >= 0) pend[last_g] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
